// File: rtl/stack_ptr_16.sv
// Bidirectional 16-bit stack pointer over [BASE, LIMIT] with empty/full flags and a sticky error.
// Latency: sp/err/hwm update one cycle after the request edge; top_addr, empty, full follow sp combinationally.
// Backpressure: none; a push on full or pop on empty is dropped and sets err. Optional hwm via STACK_PTR_HIGH_WATER_EN.
module stack_ptr_16 #(
    parameter logic [15:0] BASE  = 16'd256,
    parameter logic [15:0] LIMIT = 16'd2047
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] sp,
    output logic [15:0] top_addr,
    output logic        empty,
    output logic        full,
`ifdef STACK_PTR_HIGH_WATER_EN
    output logic [15:0] hwm,
`endif
    output logic        err
);

    localparam logic [15:0] FULL_SP = LIMIT + 16'd1;

    logic [15:0] next_sp;
    logic        next_err;

    assign top_addr = sp - 16'd1;
    assign empty    = (sp == BASE);
    assign full     = (sp == FULL_SP);

    // Push together with pop is a replace-top: pointer and error both hold.
    always_comb begin
        next_sp  = sp;
        next_err = err;
        if (load) begin
            next_sp  = in;
            next_err = 1'b0;
        end else if (push && !pop) begin
            if (full) next_err = 1'b1;
            else      next_sp  = sp + 16'd1;
        end else if (pop && !push) begin
            if (empty) next_err = 1'b1;
            else       next_sp  = sp - 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp  <= BASE;
            err <= 1'b0;
        end else begin
            sp  <= next_sp;
            err <= next_err;
        end
    end

`ifdef STACK_PTR_HIGH_WATER_EN
    always_ff @(posedge clock) begin
        if (reset)
            hwm <= BASE;
        else if (next_sp > hwm)
            hwm <= next_sp;
    end
`endif

endmodule

// File: tb/tb_stack_ptr_16.sv
// Directed bench for stack_ptr_16 with BASE=256, LIMIT=259.
module tb_stack_ptr_16;

    logic        clock = 1'b0;
    logic        reset, push, pop, load;
    logic [15:0] in;
    logic [15:0] sp, top_addr;
    logic        empty, full, err;
`ifdef STACK_PTR_HIGH_WATER_EN
    logic [15:0] hwm;
`endif

    int total = 0;
    int bad   = 0;

    stack_ptr_16 #(.BASE(16'd256), .LIMIT(16'd259)) dut (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .load     (load),
        .in       (in),
        .sp       (sp),
        .top_addr (top_addr),
        .empty    (empty),
        .full     (full),
`ifdef STACK_PTR_HIGH_WATER_EN
        .hwm      (hwm),
`endif
        .err      (err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, act=stuck exp=finished");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic ld, input logic [15:0] d);
        reset = r; push = pu; pop = po; load = ld; in = d;
        @(posedge clock);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0; load = 1'b0; in = 16'd0;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 16'd0);
        total++; if (sp !== 16'd256) begin bad++; $display("FAIL reset_sp act=%0d exp=256", sp); end
        total++; if (top_addr !== 16'd255) begin bad++; $display("FAIL reset_top act=%0d exp=255", top_addr); end
        total++; if ({empty, full, err} !== 3'b100) begin bad++; $display("FAIL reset_flags act=%b exp=100", {empty, full, err}); end
    endtask

    task automatic test_push_fill;
        logic [15:0] exp_sp [4];
        exp_sp[0] = 16'd257; exp_sp[1] = 16'd258; exp_sp[2] = 16'd259; exp_sp[3] = 16'd260;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 16'd0);
            total++; if (sp !== exp_sp[i]) begin bad++; $display("FAIL push%0d_sp act=%0d exp=%0d", i, sp, exp_sp[i]); end
            total++; if (full !== (i == 3)) begin bad++; $display("FAIL push%0d_full act=%b exp=%b", i, full, (i == 3)); end
        end
        total++; if ({empty, err} !== 2'b00) begin bad++; $display("FAIL full_empty_err act=%b exp=00", {empty, err}); end
        total++; if (top_addr !== 16'd259) begin bad++; $display("FAIL full_top act=%0d exp=259", top_addr); end
    endtask

    task automatic test_overflow;
        step(0, 1, 0, 0, 16'd0);
        total++; if ({sp, err} !== {16'd260, 1'b1}) begin bad++; $display("FAIL ovf act=sp%0d/err%b exp=sp260/err1", sp, err); end
        step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, err, full} !== {16'd259, 1'b1, 1'b0}) begin bad++; $display("FAIL ovf_pop act=sp%0d/err%b/full%b exp=sp259/err1/full0", sp, err, full); end
        step(0, 0, 0, 1, 16'd256);
        total++; if ({sp, err, empty} !== {16'd256, 1'b0, 1'b1}) begin bad++; $display("FAIL load_clr act=sp%0d/err%b/empty%b exp=sp256/err0/empty1", sp, err, empty); end
    endtask

    task automatic test_underflow;
        step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, err} !== {16'd256, 1'b1}) begin bad++; $display("FAIL unf act=sp%0d/err%b exp=sp256/err1", sp, err); end
        total++; if (top_addr !== 16'd255) begin bad++; $display("FAIL unf_top act=%0d exp=255", top_addr); end
        step(0, 1, 1, 0, 16'd0);
        total++; if ({sp, err} !== {16'd256, 1'b1}) begin bad++; $display("FAIL replace_top act=sp%0d/err%b exp=sp256/err1", sp, err); end
        step(0, 0, 0, 0, 16'd0);
        total++; if ({sp, err} !== {16'd256, 1'b1}) begin bad++; $display("FAIL idle_hold act=sp%0d/err%b exp=sp256/err1", sp, err); end
    endtask

    task automatic test_wrap;
        step(0, 0, 0, 1, 16'hFFFF);
        step(0, 1, 0, 0, 16'd0);
        total++; if (sp !== 16'h0000) begin bad++; $display("FAIL wrap_sp act=%h exp=0000", sp); end
        total++; if ({full, empty, err} !== 3'b000) begin bad++; $display("FAIL wrap_flags act=%b exp=000", {full, empty, err}); end
        total++; if (top_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_top act=%h exp=ffff", top_addr); end
        step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, err} !== {16'hFFFF, 1'b0}) begin bad++; $display("FAIL wrap_pop act=%h/err%b exp=ffff/err0", sp, err); end
    endtask

    task automatic test_priority;
        step(0, 0, 0, 1, 16'd258);
        step(0, 0, 1, 0, 16'd0);
        step(0, 0, 1, 0, 16'd0);
        step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, err} !== {16'd256, 1'b1}) begin bad++; $display("FAIL pre_prio act=sp%0d/err%b exp=sp256/err1", sp, err); end
        step(0, 0, 0, 1, 16'd258);
        step(1, 1, 0, 0, 16'd0);
        total++; if ({sp, err} !== {16'd256, 1'b0}) begin bad++; $display("FAIL reset_wins act=sp%0d/err%b exp=sp256/err0", sp, err); end
        step(0, 0, 0, 1, 16'd258);
        step(0, 1, 0, 1, 16'd300);
        total++; if (sp !== 16'd300) begin bad++; $display("FAIL load_wins act=%0d exp=300", sp); end
        step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, empty, err} !== {16'd299, 1'b0, 1'b0}) begin bad++; $display("FAIL outside_pop act=sp%0d/empty%b/err%b exp=sp299/empty0/err0", sp, empty, err); end
    endtask

`ifdef STACK_PTR_HIGH_WATER_EN
    task automatic test_high_water;
        step(1, 0, 0, 0, 16'd0);
        total++; if (hwm !== 16'd256) begin bad++; $display("FAIL hwm_reset act=%0d exp=256", hwm); end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'd0);
        total++; if (hwm !== 16'd259) begin bad++; $display("FAIL hwm_push act=%0d exp=259", hwm); end
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'd0);
        total++; if ({sp, hwm} !== {16'd257, 16'd259}) begin bad++; $display("FAIL hwm_pop act=sp%0d/hwm%0d exp=sp257/hwm259", sp, hwm); end
        step(0, 0, 0, 1, 16'd1000);
        total++; if (hwm !== 16'd1000) begin bad++; $display("FAIL hwm_load act=%0d exp=1000", hwm); end
        step(0, 0, 0, 1, 16'd300);
        total++; if (hwm !== 16'd1000) begin bad++; $display("FAIL hwm_load_low act=%0d exp=1000", hwm); end
        step(1, 0, 0, 0, 16'd0);
        total++; if (hwm !== 16'd256) begin bad++; $display("FAIL hwm_rereset act=%0d exp=256", hwm); end
    endtask
`endif

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; load = 1'b0; in = 16'd0;
        @(negedge clock);
        test_reset();
        test_push_fill();
        test_overflow();
        test_underflow();
        test_wrap();
        test_priority();
`ifdef STACK_PTR_HIGH_WATER_EN
        test_high_water();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
